gcd_sub_engine: RTL and testbench
=================================

GCD_SUB_ENGINE -- requirements
Module: gcd_sub_engine

Interface
REQ-001 Parameter WIDTH, default 4: operand, result and iteration-count width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, unsigned; sampled with start.
REQ-006 b  input  WIDTH  operand B, unsigned; sampled with start.
REQ-007 busy  output  1  high while the engine is in CALC or DONE.
REQ-008 done  output  1  one-cycle pulse; result, iters and err are valid in this cycle.
REQ-009 result  output  WIDTH  GCD of the latched operands.
REQ-010 iters  output  WIDTH  number of subtractions performed.
REQ-011 err  output  1  high when both operands were zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at an edge: latch a into internal register x and b into internal register y, clear the iteration counter, go to CALC.
REQ-014 IDLE with start=0: no register SHALL change.
REQ-015 CALC, at each edge, SHALL apply the first matching rule in this order:
- x==0 and y==0: result<=0, err<=1, go to DONE.
- x==0: result<=y, go to DONE.
- y==0: result<=x, go to DONE.
- x==y: result<=x, go to DONE.
- x>y: x<=x-y, counter+1.
- otherwise: y<=y-x, counter+1.
REQ-016 Subtraction SHALL be unsigned WIDTH-bit, and the smaller value SHALL always be subtracted from the larger, so that no borrow ever occurs.
REQ-017 The iteration counter SHALL be WIDTH bits wide; its maximum of 2^WIDTH-2 fits without saturation.
REQ-018 DONE SHALL last exactly one cycle with done=1, after which the FSM returns to IDLE.
REQ-019 done SHALL be a registered output that is high only while the FSM is in DONE.
REQ-020 When the start edge is edge 0 and N subtractions are needed, done SHALL be high in the cycle following edge N+1.
REQ-021 result, iters and err SHALL hold their values from the moment DONE is entered until the next accepted start.
REQ-022 An accepted start SHALL clear err, and SHALL leave result and iters unchanged until the next entry to DONE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 A start arriving in the DONE cycle SHALL NOT be accepted.
REQ-025 Changes on a and b outside the start-sampling edge SHALL have no effect.
REQ-026 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force:
- state=IDLE;
- busy=0, done=0, err=0;
- result=0, iters=0;
- x=0, y=0 and the counter=0.
REQ-028 Assertion of reset in the middle of CALC SHALL abort the computation with no done pulse.
REQ-029 After reset is released, the first start SHALL be accepted normally.
REQ-030 The block SHALL leave IDLE only on an accepted start; reset release alone SHALL NOT start a computation.

Verification (WIDTH=4)
REQ-031 Basic case: a=12, b=8, start at edge 0 -> done high after edge 3, result=4, iters=2, err=0, busy high from edge 0 to edge 3 inclusive.
REQ-032 Maximum iterations: a=15, b=1 -> result=1, iters=14, done high after edge 15.
REQ-033 Equal operands and zeros:
- a=7, b=7 -> result=7, iters=0, done after edge 1.
- a=0, b=9 -> result=9, err=0.
- a=0, b=0 -> result=0, err=1.
REQ-034 Start while busy: a=12, b=8 accepted; start pulsed with a=5, b=5 at edges 1 and 3 -> both ignored, result=4; the next start in IDLE gives result=5.
REQ-035 Mid-operation reset: a=15, b=1 accepted; rst_n low at edge 5 -> all outputs at 0 immediately, no done pulse; after release, a=6, b=4 -> result=2, iters=2.
REQ-036 Hold behaviour: after done, outputs hold for 10 idle cycles while a and b toggle randomly -> result, iters and err unchanged and done=0 throughout.

Source files
------------

// File: rtl/gcd_sub_engine_if.sv
// Handshake and result bundle for the subtractive GCD engine.
// The master drives the request; the slave (the engine) returns status and results.
interface gcd_sub_engine_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] iters;
  logic             err;

  modport master (
    output start, a, b,
    input  busy, done, result, iters, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, iters, err
  );
endinterface

// File: rtl/gcd_sub_engine.sv
// Subtractive GCD engine: repeatedly subtracts the smaller operand from the larger
// until one is zero or both match, then presents the result for one DONE cycle.
module gcd_sub_engine #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gcd_sub_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_iters;
  logic             r_err;
  logic             r_done;

  logic             w_busy;
  logic             w_accept;
  logic             w_finish;
  logic [WIDTH-1:0] w_fin_val;
  logic             w_fin_err;

  // Smaller value always comes off the larger one, so the difference never borrows.
  function automatic logic [WIDTH-1:0] f_diff(input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo);
    return hi - lo;
  endfunction

  always_comb begin
    w_finish  = (r_x == '0) || (r_y == '0) || (r_x == r_y);
    w_fin_val = (r_x == '0) ? r_y : r_x;
    w_fin_err = (r_x == '0) && (r_y == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (w_finish)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && bus.start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_iters  <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_CALC) && w_finish;
      if (w_accept) begin
        r_x   <= bus.a;
        r_y   <= bus.b;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (r_state == S_CALC) begin
        if (w_finish) begin
          r_result <= w_fin_val;
          r_iters  <= r_cnt;
          r_err    <= w_fin_err;
        end else if (r_x > r_y) begin
          r_x   <= f_diff(r_x, r_y);
          r_cnt <= r_cnt + WIDTH'(1);
        end else begin
          r_y   <= f_diff(r_y, r_x);
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.iters  = r_iters;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_gcd_sub_engine.sv
// Directed bench for gcd_sub_engine: expected results go into a scoreboard queue,
// and a monitor pops and compares them whenever the engine pulses done.
module tb_gcd_sub_engine;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic         e;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [W-1:0] last_result = '0;
  logic [W-1:0] last_iters  = '0;
  logic         last_err    = 1'b0;

  gcd_sub_engine_if #(.WIDTH(W)) bus ();

  gcd_sub_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending result at %0t", $time);
      end else begin
        exp_t t;
        t = sb.pop_front();
        check("sb_result", 32'(bus.result), 32'(t.r));
        check("sb_iters",  32'(bus.iters),  32'(t.i));
        check("sb_err",    32'(bus.err),    32'(t.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one computation needing n subtractions and check done/busy timing.
  task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] er, input logic [W-1:0] ei,
                     input logic ee, input int n);
    exp_t t;
    t.r = er; t.i = ei; t.e = ee;
    sb.push_back(t);
    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("err_cleared",      32'(bus.err), 32'd0);
    check("result_held",      32'(bus.result), 32'(last_result));
    check("iters_held",       32'(bus.iters), 32'(last_iters));
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      if (k <= n) check("done_early", 32'(bus.done), 32'd0);
      else        check("done_on_time", 32'(bus.done), 32'd1);
    end
    tick();
    check("done_pulse_end", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    last_result = er;
    last_iters  = ei;
    last_err    = ee;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t t;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #12;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_iters",  32'(bus.iters),  32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_start_on_release", 32'(bus.busy), 32'd0);

    run(4'd12, 4'd8, 4'd4, 4'd2, 1'b0, 2);

    for (int c = 0; c < 10; c++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      tick();
      check("hold_result", 32'(bus.result), 32'd4);
      check("hold_iters",  32'(bus.iters),  32'd2);
      check("hold_err",    32'(bus.err),    32'd0);
      check("hold_done",   32'(bus.done),   32'd0);
    end

    run(4'd15, 4'd1, 4'd1, 4'd14, 1'b0, 14);
    run(4'd7,  4'd7, 4'd7, 4'd0,  1'b0, 0);
    run(4'd0,  4'd9, 4'd9, 4'd0,  1'b0, 0);
    run(4'd0,  4'd0, 4'd0, 4'd0,  1'b1, 0);
    run(4'd9,  4'd0, 4'd9, 4'd0,  1'b0, 0);
    run(4'd6,  4'd9, 4'd3, 4'd2,  1'b0, 2);

    // Starts during CALC and during DONE must be ignored.
    t.r = 4'd4; t.i = 4'd2; t.e = 1'b0;
    sb.push_back(t);
    bus.a = 4'd12; bus.b = 4'd8; bus.start = 1'b1;
    tick();
    bus.a = 4'd5; bus.b = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    check("busy_test_done", 32'(bus.done), 32'd1);
    tick();
    check("done_cycle_start_ignored", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    tick();
    check("still_idle", 32'(bus.busy), 32'd0);
    check("busy_test_result", 32'(bus.result), 32'd4);
    last_result = 4'd4; last_iters = 4'd2; last_err = 1'b0;
    run(4'd5, 4'd5, 4'd5, 4'd0, 1'b0, 0);

    // Abort a long computation with reset; no done may follow.
    bus.a = 4'd15; bus.b = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    check("abort_err",    32'(bus.err),    32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_iters",  32'(bus.iters),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("abort_no_restart", 32'(bus.busy), 32'd0);
    last_result = '0; last_iters = '0; last_err = 1'b0;
    run(4'd6, 4'd4, 4'd2, 4'd2, 1'b0, 2);

    repeat (2) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
